// File: rtl/rs485_pkg.sv
// Shared types and defaults for the RS-485 polling master.
package rs485_pkg;

  localparam int DEF_BAUD_NUM = 3;
  localparam int DEF_BAUD_DEN = 50;
  localparam int DEF_RESP_LEN = 18;
  localparam int DEF_FIRST_TO = 64;
  localparam int DEF_GAP_TO   = 4;

  // Accumulator wide enough to hold acc+NUM without wrapping (acc < DEN).
  localparam int ACC_W = $clog2(DEF_BAUD_DEN + DEF_BAUD_NUM);

  typedef enum logic [2:0] {
    IDLE,
    TX_SETUP,
    TX_BYTE,
    TX_GUARD,
    RX_HUNT,
    RX_BYTE,
    FINISH
  } state_t;

  function automatic int acc_width(input int num, input int den);
    return $clog2(num + den);
  endfunction

endpackage

// File: rtl/baud_nco.sv
// Fractional baud-rate NCO: one tick every DEN/NUM clocks on average.
module baud_nco
  import rs485_pkg::*;
#(
  parameter int NUM = DEF_BAUD_NUM,
  parameter int DEN = DEF_BAUD_DEN
) (
  input  logic clk80MHz,
  input  logic rst,
  input  logic clr,
  input  logic preload_half,
  output logic tick
);

  localparam int W = acc_width(NUM, DEN);
  localparam logic [W-1:0] NUM_W  = W'(NUM);
  localparam logic [W-1:0] DEN_W  = W'(DEN);
  localparam logic [W-1:0] HALF_W = W'(DEN / 2);

  logic [W-1:0] acc;
  logic [W-1:0] sum;

  assign sum  = acc + NUM_W;
  // A clear or preload restarts the phase, so no tick leaks out on that clock.
  assign tick = !clr && !preload_half && (sum >= DEN_W);

  // Phase accumulator: wraps modulo DEN, restartable at zero or half a period.
  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst)                acc <= '0;
    else if (clr)           acc <= '0;
    else if (preload_half)  acc <= HALF_W;
    else if (sum >= DEN_W)  acc <= sum - DEN_W;
    else                    acc <= sum;
  end

endmodule

// File: rtl/rs485_poll_master.sv
// RS-485 polling master: sends one command byte, turns the bus around and
// stores a fixed-length 8N1 reply into a downstream frame buffer.
//
//   state    | meaning
//   IDLE     | waiting for start
//   TX_SETUP | driver on, line idle for one bit
//   TX_BYTE  | start bit and 8 data bits, LSB first
//   TX_GUARD | stop bit; bus turnaround at its end
//   RX_HUNT  | waiting for a start edge, timeout running
//   RX_BYTE  | sampling 10 bits mid-bit, then byte write
//   FINISH   | one-clock done pulse
module rs485_poll_master
  import rs485_pkg::*;
#(
  parameter int BAUD_NUM = DEF_BAUD_NUM,
  parameter int BAUD_DEN = DEF_BAUD_DEN,
  parameter int RESP_LEN = DEF_RESP_LEN,
  parameter int FIRST_TO = DEF_FIRST_TO,
  parameter int GAP_TO   = DEF_GAP_TO
) (
  input  logic       clk80MHz,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic       UART_RX,
  output logic       UART_TX,
  output logic       UART_dTX,
  output logic       UART_dRX,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic [4:0] rx_addr,
  output logic       rx_we,
  output logic       done,
  output logic [4:0] rx_count,
  output logic       timeout_err,
  output logic       frame_err
);

  localparam int TO_MAX = (FIRST_TO > GAP_TO) ? FIRST_TO : GAP_TO;
  localparam int TO_W   = $clog2(TO_MAX + 1);
  localparam logic [TO_W-1:0] FIRST_LD = TO_W'(FIRST_TO);
  localparam logic [TO_W-1:0] GAP_LD   = TO_W'(GAP_TO);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [4:0]      LAST_IDX = 5'(RESP_LEN - 1);

  state_t          state, state_nxt;
  logic            rx_s1, rx_s2, rx_prev;
  logic            rx_fall, accept, to_expire;
  logic            tx_tick, rx_tick;
  logic [8:0]      tx_sr;
  logic [7:0]      rx_sr;
  logic [3:0]      bit_cnt;
  logic [TO_W-1:0] to_cnt;

  assign accept    = (state == IDLE) && start;
  assign rx_fall   = rx_prev && !rx_s2;
  assign to_expire = tx_tick && (to_cnt == TO_ONE);

  baud_nco #(.NUM(BAUD_NUM), .DEN(BAUD_DEN)) u_tx_nco (
    .clk80MHz     (clk80MHz),
    .rst          (rst),
    .clr          (accept),
    .preload_half (1'b0),
    .tick         (tx_tick)
  );

  baud_nco #(.NUM(BAUD_NUM), .DEN(BAUD_DEN)) u_rx_nco (
    .clk80MHz     (clk80MHz),
    .rst          (rst),
    .clr          (1'b0),
    .preload_half ((state == RX_HUNT) && rx_fall),
    .tick         (rx_tick)
  );

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst) {rx_s1, rx_s2, rx_prev} <= 3'b111;
    else     {rx_s1, rx_s2, rx_prev} <= {UART_RX, rx_s1, rx_s2};
  end

  // State register.
  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an edge in RX_HUNT wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = TX_SETUP;
      TX_SETUP: if (tx_tick) state_nxt = TX_BYTE;
      TX_BYTE:  if (tx_tick && bit_cnt == 4'd8) state_nxt = TX_GUARD;
      TX_GUARD: if (tx_tick) state_nxt = RX_HUNT;
      RX_HUNT: begin
        if (rx_fall)        state_nxt = RX_BYTE;
        else if (to_expire) state_nxt = FINISH;
      end
      RX_BYTE: begin
        if (rx_we) begin
          state_nxt = (rx_addr == LAST_IDX) ? FINISH : RX_HUNT;
        end else if (rx_tick) begin
          if (bit_cnt == 4'd0 && rx_s2)       state_nxt = RX_HUNT;
          else if (bit_cnt == 4'd9 && !rx_s2) state_nxt = FINISH;
        end
      end
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Line and handshake outputs decoded from the current state.
  always_comb begin
    UART_TX  = 1'b1;
    UART_dTX = 1'b0;
    UART_dRX = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      TX_SETUP, TX_GUARD: begin
        busy     = 1'b1;
        UART_dTX = 1'b1;
      end
      TX_BYTE: begin
        busy     = 1'b1;
        UART_dTX = 1'b1;
        UART_TX  = tx_sr[0];
      end
      RX_HUNT, RX_BYTE: begin
        busy     = 1'b1;
        UART_dRX = 1'b0;
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  // Shifters, bit counter, timeout down-counter and frame-buffer write port.
  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst) begin
      tx_sr       <= '1;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      rx_data     <= '0;
      rx_addr     <= '0;
      rx_count    <= '0;
      rx_we       <= 1'b0;
      timeout_err <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_we <= 1'b0;
      if (rx_we) begin
        rx_addr  <= rx_addr + 5'd1;
        rx_count <= rx_count + 5'd1;
      end
      case (state)
        IDLE: if (start) begin
          tx_sr       <= {cmd, 1'b0};
          bit_cnt     <= '0;
          rx_addr     <= '0;
          rx_count    <= '0;
          timeout_err <= 1'b0;
          frame_err   <= 1'b0;
        end
        TX_BYTE: if (tx_tick) begin
          tx_sr   <= {1'b1, tx_sr[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
        TX_GUARD: if (tx_tick) to_cnt <= FIRST_LD;
        RX_HUNT: begin
          if (rx_fall)        bit_cnt     <= '0;
          else if (to_expire) timeout_err <= 1'b1;
          else if (tx_tick)   to_cnt      <= to_cnt - TO_ONE;
        end
        RX_BYTE: begin
          if (rx_we) begin
            to_cnt <= GAP_LD;
          end else if (rx_tick) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              if (rx_s2) begin
                rx_we   <= 1'b1;
                rx_data <= rx_sr;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              rx_sr <= {rx_s2, rx_sr[7:1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs485_poll_master.sv
// Self-checking bench for rs485_poll_master: table-driven polls, randomized
// polls against a reply-level model, and hand-written reset/glitch sequences.
module tb_rs485_poll_master;

  localparam int BIT_NUM = 3;
  localparam int BIT_DEN = 50;
  localparam int RESP    = 18;

  logic       clk80MHz = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       UART_RX = 1'b1;
  logic       UART_TX, UART_dTX, UART_dRX, busy, rx_we, done;
  logic       timeout_err, frame_err;
  logic [7:0] rx_data;
  logic [4:0] rx_addr, rx_count;

  rs485_poll_master dut (
    .clk80MHz    (clk80MHz),
    .rst         (rst),
    .start       (start),
    .cmd         (cmd),
    .UART_RX     (UART_RX),
    .UART_TX     (UART_TX),
    .UART_dTX    (UART_dTX),
    .UART_dRX    (UART_dRX),
    .busy        (busy),
    .rx_data     (rx_data),
    .rx_addr     (rx_addr),
    .rx_we       (rx_we),
    .done        (done),
    .rx_count    (rx_count),
    .timeout_err (timeout_err),
    .frame_err   (frame_err)
  );

  always #5 clk80MHz = ~clk80MHz;

  int cyc = 0;
  always @(posedge clk80MHz) cyc <= cyc + 1;

  // Frame-buffer monitor.
  logic [4:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         done_cnt = 0, done_cyc = 0, last_we_cyc = 0;
  logic [4:0] cnt_at_done;
  logic       to_at_done, fe_at_done, busy_at_done;

  always @(negedge clk80MHz) begin
    if (rx_we) begin
      wr_addr.push_back(rx_addr);
      wr_data.push_back(rx_data);
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      cnt_at_done  = rx_count;
      to_at_done   = timeout_err;
      fe_at_done   = frame_err;
      busy_at_done = busy;
    end
  end

  int checks = 0, passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s_ctl", tag),
          {UART_TX, UART_dTX, UART_dRX, busy, rx_we, done, timeout_err, frame_err}, 8'b1010_0000);
    check($sformatf("%s_data", tag), {rx_data, rx_addr, rx_count}, 0);
  endtask

  logic [7:0] reply[RESP];

  task automatic fill_reply(input bit seq);
    for (int i = 0; i < RESP; i++) reply[i] = seq ? 8'(i * 10) : 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RX = f[i];
      repeat (((i + 1) * BIT_DEN) / BIT_NUM - (i * BIT_DEN) / BIT_NUM) @(negedge clk80MHz);
    end
  endtask

  // What the frame buffer should hold, derived from what the slave sent.
  function automatic void model(input int nsent, input int frame_at,
                                output int cnt, output bit to, output bit fe);
    if (frame_at >= 0 && frame_at < nsent) begin
      cnt = frame_at; to = 1'b0; fe = 1'b1;
    end else if (nsent >= RESP) begin
      cnt = RESP; to = 1'b0; fe = 1'b0;
    end else begin
      cnt = nsent; to = 1'b1; fe = 1'b0;
    end
  endfunction

  task automatic wait_turnaround(output int ta);
    int k;
    k = 0;
    while (UART_dTX !== 1'b0 && k < 400) begin
      @(negedge clk80MHz);
      k++;
    end
    ta = cyc;
    if (k >= 400) check("turnaround_wait", 0, 1);
  endtask

  task automatic run_poll(input string tag, input logic [7:0] c, input int delay, input int nsent,
                          input int frame_at, input bit glitch, input bit busy_start,
                          input int exp_cnt, input bit exp_to, input bit exp_fe);
    int t0, ta, busy_cyc, waited, bad, k;
    logic [9:0] txb;
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    repeat (4) @(negedge clk80MHz);
    cmd = c;
    start = 1'b1;
    @(negedge clk80MHz);
    start = 1'b0;
    busy_cyc = cyc;
    check($sformatf("%s_start_ctl", tag), {busy, UART_dTX, UART_dRX, UART_TX}, 4'b1111);
    if (busy_start) begin
      repeat (2) @(negedge clk80MHz);
      cmd = ~c;
      start = 1'b1;
      @(negedge clk80MHz);
      start = 1'b0;
    end
    k = 0;
    while (UART_TX !== 1'b0 && k < 60) begin
      @(negedge clk80MHz);
      k++;
    end
    t0 = cyc;
    txb = '0;
    if (k >= 60) check($sformatf("%s_tx_start", tag), 0, 1);
    else begin
      for (int i = 1; i <= 9; i++) begin
        while (cyc < t0 + 8 + (i * BIT_DEN) / BIT_NUM) @(negedge clk80MHz);
        txb[i] = UART_TX;
      end
      check($sformatf("%s_tx_byte", tag), txb[8:1], c);
      check($sformatf("%s_tx_stop", tag), txb[9], 1);
    end
    wait_turnaround(ta);
    check($sformatf("%s_turn_drx", tag), {UART_dTX, UART_dRX}, 2'b00);
    check_range($sformatf("%s_turn_time", tag), ta - busy_cyc, 166, 201);
    waited = 0;
    if (glitch) begin
      repeat (83) @(negedge clk80MHz);
      UART_RX = 1'b0;
      repeat (2) @(negedge clk80MHz);
      UART_RX = 1'b1;
      repeat (100) @(negedge clk80MHz);
      check($sformatf("%s_glitch_no_we", tag), wr_addr.size(), 0);
      check($sformatf("%s_glitch_listen", tag), UART_dRX, 0);
      waited = 185;
    end
    repeat ((delay * BIT_DEN) / BIT_NUM - waited) @(negedge clk80MHz);
    for (int i = 0; i < nsent; i++) begin
      send_byte(reply[i], (i == frame_at) ? 1'b0 : 1'b1);
      if (i == frame_at) break;
    end
    UART_RX = 1'b1;
    k = 0;
    while (done_cnt == 0 && k < 1500) begin
      @(negedge clk80MHz);
      k++;
    end
    repeat (3) @(negedge clk80MHz);
    check($sformatf("%s_done_cnt", tag), done_cnt, 1);
    check($sformatf("%s_rx_count", tag), cnt_at_done, exp_cnt);
    check($sformatf("%s_timeout", tag), to_at_done, exp_to);
    check($sformatf("%s_frame", tag), fe_at_done, exp_fe);
    check($sformatf("%s_busy_done", tag), busy_at_done, 0);
    check($sformatf("%s_drx_idle", tag), {UART_dRX, UART_dTX, busy}, 3'b100);
    check($sformatf("%s_n_writes", tag), wr_addr.size(), exp_cnt);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (i >= exp_cnt || wr_addr[i] != 5'(i) || wr_data[i] != reply[i]) bad++;
    check($sformatf("%s_bad_writes", tag), bad, 0);
    if (exp_cnt == RESP && !exp_to && !exp_fe)
      check($sformatf("%s_done_after_we", tag), done_cyc - last_we_cyc, 1);
    if (nsent == 0)
      check_range($sformatf("%s_silent_time", tag), done_cyc - ta, 1049, 1090);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         delay;
    int         nsent;
    int         frame_at;
    bit         glitch;
    bit         busy_start;
    bit         seq_data;
    int         exp_cnt;
    bit         exp_to;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[6];
  int   ns, fa, dl, ec, ta_r;
  bit   et, ef;

  initial begin
    vecs[0] = '{8'hA5, 30, 18, -1, 1'b0, 1'b0, 1'b1, 18, 1'b0, 1'b0};
    vecs[1] = '{8'h5A, 30,  0, -1, 1'b0, 1'b0, 1'b0,  0, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 12,  6, -1, 1'b0, 1'b0, 1'b0,  6, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 20, 18,  3, 1'b0, 1'b0, 1'b0,  3, 1'b0, 1'b1};
    vecs[4] = '{8'h0F, 30, 18, -1, 1'b1, 1'b0, 1'b0, 18, 1'b0, 1'b0};
    vecs[5] = '{8'hC6, 10, 18, -1, 1'b0, 1'b1, 1'b0, 18, 1'b0, 1'b0};

    repeat (5) @(negedge clk80MHz);
    check_reset("reset");
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      fill_reply(vecs[v].seq_data);
      run_poll($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].delay, vecs[v].nsent,
               vecs[v].frame_at, vecs[v].glitch, vecs[v].busy_start,
               vecs[v].exp_cnt, vecs[v].exp_to, vecs[v].exp_fe);
    end

    for (int r = 0; r < 4; r++) begin
      fill_reply(1'b0);
      ns = (r == 0) ? RESP : int'($urandom_range(0, RESP));
      fa = (ns > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, ns - 1)) : -1;
      dl = $urandom_range(1, 50);
      model(ns, fa, ec, et, ef);
      run_poll($sformatf("rnd%0d", r), 8'($urandom), dl, ns, fa, 1'b0, 1'b0, ec, et, ef);
    end

    // Reset in the middle of reply byte 7.
    fill_reply(1'b0);
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    repeat (4) @(negedge clk80MHz);
    cmd = 8'h77;
    start = 1'b1;
    @(negedge clk80MHz);
    start = 1'b0;
    wait_turnaround(ta_r);
    repeat ((10 * BIT_DEN) / BIT_NUM) @(negedge clk80MHz);
    for (int i = 0; i < 7; i++) send_byte(reply[i], 1'b1);
    UART_RX = 1'b0;
    repeat (40) @(negedge clk80MHz);
    check("rstmid_writes", wr_addr.size(), 7);
    check("rstmid_in_rx", {busy, UART_dRX}, 2'b10);
    rst = 1'b1;
    @(posedge clk80MHz);
    #1;
    check_reset("rstmid");
    UART_RX = 1'b1;
    repeat (3) @(negedge clk80MHz);
    rst = 1'b0;
    repeat (300) @(negedge clk80MHz);
    check("rstmid_no_done", done_cnt, 0);
    check("rstmid_idle", {busy, UART_dTX, UART_dRX}, 3'b001);

    fill_reply(1'b1);
    run_poll("post_rst", 8'hE1, 20, 18, -1, 1'b0, 1'b0, 18, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
